// File: rtl/fetch_sequencer.sv
// Byte-serial instruction fetch: reads one byte per cycle, assembles big-endian
// 32-bit words and queues them with their PC in a small prefetch FIFO.
module fetch_sequencer #(
    parameter int          MEM_ADDR_BITS = 16,
    parameter int          FIFO_DEPTH    = 4,
    parameter logic [31:0] RESET_PC      = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc,
    output logic        fetch_fault,
    output logic        fsm_state
);

    localparam int             PW       = $clog2(FIFO_DEPTH);
    localparam logic [PW:0]    CNT_FULL = (PW + 1)'(FIFO_DEPTH);
    localparam logic [PW:0]    CNT_ONE  = 1;
    localparam logic [PW-1:0]  PTR_ONE  = 1;

    typedef enum logic {FETCH = 1'b0, FAULT = 1'b1} state_t;

    state_t      state, state_nx;
    logic [29:0] fetch_word, fetch_word_nx;
    logic [1:0]  byte_cnt, byte_cnt_nx;
    logic [23:0] asm_q;
    logic [31:0] fifo_inst [FIFO_DEPTH];
    logic [31:0] fifo_pc   [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic rd_en, push, pop, out_of_range, has_room;
    logic unused_bits;

    assign unused_bits = ^redirect_pc[1:0];

    // Handshake: a word transfers on any cycle with inst_valid & inst_ready;
    // while inst_valid is high and inst_ready low the head entry holds still.
    // A redirect masks inst_valid so a flushed entry can never be consumed.
    assign inst_valid   = (count != '0) && !redirect_valid;
    assign pop          = inst_valid && inst_ready;
    assign inst_out     = fifo_inst[rd_ptr];
    assign inst_pc      = fifo_pc[rd_ptr];
    assign has_room     = count < CNT_FULL;
    assign out_of_range = |({fetch_word, 2'b00} >> MEM_ADDR_BITS);
    assign mem_addr     = {fetch_word, byte_cnt};
    assign mem_rd       = rd_en && !rst;
    assign fetch_fault  = (state == FAULT) && (count == '0);
    assign fsm_state    = state;

    always_comb begin
        state_nx      = state;
        fetch_word_nx = fetch_word;
        byte_cnt_nx   = byte_cnt;
        rd_en         = 1'b0;
        push          = 1'b0;
        if (state == FETCH) begin
            // A started word always finishes: its slot was reserved at byte 0.
            if (byte_cnt != 2'd0)
                rd_en = 1'b1;
            else if (out_of_range)
                state_nx = FAULT;
            else if (has_room || pop)
                rd_en = 1'b1;
            if (rd_en) begin
                byte_cnt_nx = byte_cnt + 2'd1;
                if (byte_cnt == 2'd3) begin
                    push          = 1'b1;
                    fetch_word_nx = fetch_word + 30'd1;
                end
            end
        end
        if (redirect_valid) begin
            state_nx      = FETCH;
            fetch_word_nx = redirect_pc[31:2];
            byte_cnt_nx   = 2'd0;
            push          = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= FETCH;
            fetch_word <= RESET_PC[31:2];
            byte_cnt   <= 2'd0;
            asm_q      <= '0;
        end else begin
            state      <= state_nx;
            fetch_word <= fetch_word_nx;
            byte_cnt   <= byte_cnt_nx;
            if (rd_en && !redirect_valid) begin
                case (byte_cnt)
                    2'd0:    asm_q[23:16] <= mem_rdata;
                    2'd1:    asm_q[15:8]  <= mem_rdata;
                    2'd2:    asm_q[7:0]   <= mem_rdata;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_inst[i] <= '0;
                fifo_pc[i]   <= '0;
            end
        end else if (redirect_valid) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fifo_inst[wr_ptr] <= {asm_q, mem_rdata};
                fifo_pc[wr_ptr]   <= {fetch_word, 2'b00};
                wr_ptr            <= wr_ptr + PTR_ONE;
            end
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: vector table for the reset/first-word
// timeline, hand-written sequences for backpressure, redirect, fault and reset.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_rdata;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        fetch_fault;
    logic        fsm_state;

    logic [7:0]  mem [0:65535];
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rdy;
        logic        exp_rd;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_inst;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs [10];

    fetch_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_addr       (mem_addr),
        .mem_rd         (mem_rd),
        .mem_rdata      (mem_rdata),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_out       (inst_out),
        .inst_pc        (inst_pc),
        .fetch_fault    (fetch_fault),
        .fsm_state      (fsm_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[15:0]];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [31:0] word_at(input logic [31:0] a);
        if (a == 32'h0)      return 32'h0050_0093;
        else if (a == 32'h4) return 32'h0010_0113;
        else                 return 32'hA500_0000 ^ a;
    endfunction

    function automatic vec_t mk(input logic rdy, input logic rd, input logic [31:0] addr,
                                input logic v, input logic [31:0] inst, input logic [31:0] pc);
        vec_t r;
        r.rdy = rdy; r.exp_rd = rd; r.exp_addr = addr;
        r.exp_valid = v; r.exp_inst = inst; r.exp_pc = pc;
        return r;
    endfunction

    // scoreboard helpers
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic rdy);
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        inst_ready = rdy;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // No read may ever address beyond the 64 KiB memory.
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (mem_rd && mem_addr[31:16] != 16'h0) begin
                errors++;
                $display("FAIL range: mem_rd with mem_addr %h", mem_addr);
            end
        end
    end

    initial begin
        for (int a = 0; a < 65536; a += 4) begin
            logic [31:0] w;
            w = word_at(32'(a));
            mem[a]     = w[31:24];
            mem[a + 1] = w[23:16];
            mem[a + 2] = w[15:8];
            mem[a + 3] = w[7:0];
        end

        vecs[0] = mk(1'b1, 1'b1, 32'd0, 1'b0, 32'h0, 32'h0);
        vecs[1] = mk(1'b1, 1'b1, 32'd1, 1'b0, 32'h0, 32'h0);
        vecs[2] = mk(1'b1, 1'b1, 32'd2, 1'b0, 32'h0, 32'h0);
        vecs[3] = mk(1'b1, 1'b1, 32'd3, 1'b0, 32'h0, 32'h0);
        vecs[4] = mk(1'b1, 1'b1, 32'd4, 1'b1, 32'h0050_0093, 32'h0);
        vecs[5] = mk(1'b1, 1'b1, 32'd5, 1'b0, 32'h0, 32'h0);
        vecs[6] = mk(1'b1, 1'b1, 32'd6, 1'b0, 32'h0, 32'h0);
        vecs[7] = mk(1'b1, 1'b1, 32'd7, 1'b0, 32'h0, 32'h0);
        vecs[8] = mk(1'b1, 1'b1, 32'd8, 1'b1, 32'h0010_0113, 32'h4);
        vecs[9] = mk(1'b1, 1'b1, 32'd9, 1'b0, 32'h0, 32'h0);

        // reset state
        #2;
        chk1("rst mem_rd", mem_rd, 1'b0);
        chk("rst mem_addr", mem_addr, 32'h0);
        chk1("rst inst_valid", inst_valid, 1'b0);
        chk("rst inst_out", inst_out, 32'h0);
        chk("rst inst_pc", inst_pc, 32'h0);
        chk1("rst fetch_fault", fetch_fault, 1'b0);
        chk1("rst state", fsm_state, 1'b0);

        // first words after reset
        do_reset(1'b1);
        for (int i = 0; i < 10; i++) begin
            inst_ready = vecs[i].rdy;
            #1;
            chk1($sformatf("v%0d mem_rd", i), mem_rd, vecs[i].exp_rd);
            chk($sformatf("v%0d mem_addr", i), mem_addr, vecs[i].exp_addr);
            chk1($sformatf("v%0d inst_valid", i), inst_valid, vecs[i].exp_valid);
            if (vecs[i].exp_valid) begin
                chk($sformatf("v%0d inst_out", i), inst_out, vecs[i].exp_inst);
                chk($sformatf("v%0d inst_pc", i), inst_pc, vecs[i].exp_pc);
            end
            next_cycle();
        end

        // backpressure: FIFO fills, head holds, drain in order
        do_reset(1'b0);
        for (int c = 0; c < 40; c++) begin
            #1;
            if (c >= 4) begin
                chk1($sformatf("bp c%0d valid", c), inst_valid, 1'b1);
                chk($sformatf("bp c%0d pc", c), inst_pc, 32'h0);
                chk($sformatf("bp c%0d out", c), inst_out, 32'h0050_0093);
            end
            if (c >= 16) chk1($sformatf("bp c%0d mem_rd", c), mem_rd, 1'b0);
            next_cycle();
        end
        inst_ready = 1'b1;
        #1;
        chk1("bp pop0 mem_rd", mem_rd, 1'b1);
        chk("bp pop0 mem_addr", mem_addr, 32'd16);
        chk("bp pop0 pc", inst_pc, 32'h0);
        next_cycle();
        chk("bp pop1 pc", inst_pc, 32'h4);
        chk("bp pop1 out", inst_out, 32'h0010_0113);
        chk("bp pop1 mem_addr", mem_addr, 32'd17);
        next_cycle();
        chk("bp pop2 pc", inst_pc, 32'h8);
        next_cycle();
        chk("bp pop3 pc", inst_pc, 32'hC);
        chk("bp pop3 out", inst_out, word_at(32'hC));
        next_cycle();
        chk1("bp new valid", inst_valid, 1'b1);
        chk("bp new pc", inst_pc, 32'h10);
        chk("bp new out", inst_out, word_at(32'h10));

        // redirect mid-word with two entries queued
        do_reset(1'b0);
        repeat (10) next_cycle();
        chk1("rd pre valid", inst_valid, 1'b1);
        chk("rd pre mem_addr", mem_addr, 32'd10);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0026;
        inst_ready = 1'b1;
        #1;
        chk1("rd edge valid", inst_valid, 1'b0);
        next_cycle();
        redirect_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("rd b%0d mem_addr", k), mem_addr, 32'h24 + 32'(k));
            chk1($sformatf("rd b%0d mem_rd", k), mem_rd, 1'b1);
            chk1($sformatf("rd b%0d valid", k), inst_valid, 1'b0);
            next_cycle();
        end
        chk1("rd new valid", inst_valid, 1'b1);
        chk("rd new pc", inst_pc, 32'h24);
        chk("rd new out", inst_out, word_at(32'h24));

        // top of memory: two words, then fault
        inst_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_FFF8;
        next_cycle();
        redirect_valid = 1'b0;
        for (int j = 0; j < 12; j++) begin
            #1;
            chk1($sformatf("flt c%0d fault", j), fetch_fault, 1'b0);
            if (j < 8) begin
                chk($sformatf("flt c%0d mem_addr", j), mem_addr, 32'hFFF8 + 32'(j));
                chk1($sformatf("flt c%0d mem_rd", j), mem_rd, 1'b1);
            end else begin
                chk1($sformatf("flt c%0d mem_rd", j), mem_rd, 1'b0);
                chk($sformatf("flt c%0d pc", j), inst_pc, 32'hFFF8);
                chk($sformatf("flt c%0d out", j), inst_out, word_at(32'hFFF8));
            end
            next_cycle();
        end
        inst_ready = 1'b1;
        #1;
        chk("flt pop0 pc", inst_pc, 32'hFFF8);
        chk1("flt pop0 fault", fetch_fault, 1'b0);
        next_cycle();
        chk("flt pop1 pc", inst_pc, 32'hFFFC);
        chk("flt pop1 out", inst_out, word_at(32'hFFFC));
        chk1("flt pop1 fault", fetch_fault, 1'b0);
        next_cycle();
        for (int j = 0; j < 3; j++) begin
            chk1($sformatf("flt hold%0d fault", j), fetch_fault, 1'b1);
            chk1($sformatf("flt hold%0d valid", j), inst_valid, 1'b0);
            chk1($sformatf("flt hold%0d mem_rd", j), mem_rd, 1'b0);
            chk1($sformatf("flt hold%0d state", j), fsm_state, 1'b1);
            next_cycle();
        end
        redirect_valid = 1'b1;
        redirect_pc = 32'h0;
        next_cycle();
        redirect_valid = 1'b0;
        #1;
        chk1("flt clr fault", fetch_fault, 1'b0);
        chk("flt clr mem_addr", mem_addr, 32'h0);
        chk1("flt clr mem_rd", mem_rd, 1'b1);

        // asynchronous reset mid-word with three entries queued
        do_reset(1'b0);
        repeat (13) next_cycle();
        chk1("ar pre valid", inst_valid, 1'b1);
        chk("ar pre mem_addr", mem_addr, 32'd13);
        #1;
        rst = 1'b1;
        #1;
        chk1("ar mem_rd", mem_rd, 1'b0);
        chk("ar mem_addr", mem_addr, 32'h0);
        chk1("ar valid", inst_valid, 1'b0);
        chk("ar out", inst_out, 32'h0);
        chk("ar pc", inst_pc, 32'h0);
        chk1("ar fault", fetch_fault, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        inst_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("ar b%0d mem_addr", k), mem_addr, 32'(k));
            chk1($sformatf("ar b%0d mem_rd", k), mem_rd, 1'b1);
            chk1($sformatf("ar b%0d valid", k), inst_valid, 1'b0);
            next_cycle();
        end
        chk1("ar new valid", inst_valid, 1'b1);
        chk("ar new pc", inst_pc, 32'h0);
        chk("ar new out", inst_out, 32'h0050_0093);

        // redirect on a cycle that would otherwise pop
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0040;
        #1;
        chk1("rp valid", inst_valid, 1'b0);
        next_cycle();
        redirect_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk1($sformatf("rp b%0d valid", k), inst_valid, 1'b0);
            chk($sformatf("rp b%0d mem_addr", k), mem_addr, 32'h40 + 32'(k));
            next_cycle();
        end
        chk1("rp new valid", inst_valid, 1'b1);
        chk("rp new pc", inst_pc, 32'h40);
        chk("rp new out", inst_out, word_at(32'h40));

        // final report
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
